// File: rtl/intersection_phase_scheduler.sv
// intersection_phase_scheduler
//   Two-road intersection sequencer: NS/EW car lights, all-red clearance,
//   on-demand pedestrian WALK and a maintenance flashing-yellow mode.
//   All timing advances on the 1-cycle tick enable only.
// Ports:
//   clk, reset    system clock, asynchronous active-high reset
//   tick          1-cycle timing enable
//   ped_req       pedestrian button (sampled every clk)
//   flash_mode    maintenance flashing-yellow request
//   ns_light      NS light {green,yellow,red}
//   ew_light      EW light {green,yellow,red}
//   walk          pedestrian WALK lamp
//   ped_pending   latched, not-yet-served pedestrian request
//   remaining     ticks left in current phase minus 1
//   phase         state code for debug/display
module intersection_phase_scheduler #(
  parameter int CW       = 4,
  parameter int T_GREEN  = 9,
  parameter int T_YELLOW = 3,
  parameter int T_ALLRED = 1,
  parameter int T_WALK   = 6
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          tick,
  input  logic          ped_req,
  input  logic          flash_mode,
  output logic [2:0]    ns_light,
  output logic [2:0]    ew_light,
  output logic          walk,
  output logic          ped_pending,
  output logic [CW-1:0] remaining,
  output logic [2:0]    phase
);

  typedef enum logic [2:0] {
    ALLRED    = 3'd0,
    NS_GREEN  = 3'd1,
    NS_YELLOW = 3'd2,
    EW_GREEN  = 3'd3,
    EW_YELLOW = 3'd4,
    WALK      = 3'd5,
    FLASH     = 3'd6
  } state_t;

  localparam logic [CW-1:0] R_GREEN  = CW'(T_GREEN - 1);
  localparam logic [CW-1:0] R_YELLOW = CW'(T_YELLOW - 1);
  localparam logic [CW-1:0] R_ALLRED = CW'(T_ALLRED - 1);
  localparam logic [CW-1:0] R_WALK   = CW'(T_WALK - 1);

  localparam logic [2:0] L_GREEN  = 3'b100;
  localparam logic [2:0] L_YELLOW = 3'b010;
  localparam logic [2:0] L_RED    = 3'b001;

  state_t        state, state_n;
  logic [CW-1:0] rem_n;
  logic          next_ew, next_ew_n;
  logic          ped_n;
  logic          flash_on, flash_on_n;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ALLRED;
      remaining   <= R_ALLRED;
      next_ew     <= 1'b0;
      ped_pending <= 1'b0;
      flash_on    <= 1'b0;
    end else begin
      state       <= state_n;
      remaining   <= rem_n;
      next_ew     <= next_ew_n;
      ped_pending <= ped_n;
      flash_on    <= flash_on_n;
    end
  end

  always_comb begin
    state_n    = state;
    rem_n      = remaining;
    next_ew_n  = next_ew;
    flash_on_n = flash_on;
    ped_n      = ped_pending;

    // Requests made while walking are dropped; everywhere else they latch.
    if (ped_req && state != WALK) ped_n = 1'b1;

    if (tick) begin
      if (state == FLASH) begin
        if (!flash_mode) begin
          state_n   = ALLRED;
          rem_n     = R_ALLRED;
          next_ew_n = 1'b0;
        end else begin
          flash_on_n = ~flash_on;
        end
      end else if (flash_mode) begin
        // Flash pre-empts any phase immediately, starting with yellow lit.
        state_n    = FLASH;
        rem_n      = '0;
        flash_on_n = 1'b1;
      end else if (remaining != '0) begin
        rem_n = remaining - 1'b1;
      end else begin
        unique case (state)
          ALLRED: begin
            if (ped_pending) begin
              state_n = WALK;
              rem_n   = R_WALK;
            end else if (next_ew) begin
              state_n = EW_GREEN;
              rem_n   = R_GREEN;
            end else begin
              state_n = NS_GREEN;
              rem_n   = R_GREEN;
            end
          end
          NS_GREEN: begin
            state_n = NS_YELLOW;
            rem_n   = R_YELLOW;
          end
          NS_YELLOW: begin
            state_n   = ALLRED;
            rem_n     = R_ALLRED;
            next_ew_n = 1'b1;
          end
          EW_GREEN: begin
            state_n = EW_YELLOW;
            rem_n   = R_YELLOW;
          end
          EW_YELLOW: begin
            state_n   = ALLRED;
            rem_n     = R_ALLRED;
            next_ew_n = 1'b0;
          end
          WALK: begin
            state_n = next_ew ? EW_GREEN : NS_GREEN;
            rem_n   = R_GREEN;
          end
          default: begin
            state_n = ALLRED;
            rem_n   = R_ALLRED;
          end
        endcase
      end
    end

    // Serving the request clears it, even against a same-cycle press.
    if (state_n == WALK && state != WALK) ped_n = 1'b0;
  end

  always_comb begin
    ns_light = L_RED;
    ew_light = L_RED;
    walk     = 1'b0;
    unique case (state)
      NS_GREEN:  ns_light = L_GREEN;
      NS_YELLOW: ns_light = L_YELLOW;
      EW_GREEN:  ew_light = L_GREEN;
      EW_YELLOW: ew_light = L_YELLOW;
      WALK:      walk     = 1'b1;
      FLASH: begin
        ns_light = flash_on ? L_YELLOW : 3'b000;
        ew_light = flash_on ? L_YELLOW : 3'b000;
      end
      default: ;
    endcase
  end

  assign phase = state;

endmodule

// File: tb/tb_intersection_phase_scheduler.sv
module tb_intersection_phase_scheduler;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tick = 1'b0;
  logic       ped_req = 1'b0;
  logic       flash_mode = 1'b0;
  logic [2:0] ns_light, ew_light;
  logic       walk, ped_pending;
  logic [3:0] remaining;
  logic [2:0] phase;

  int checks = 0;
  int errors = 0;

  intersection_phase_scheduler #(
    .CW(4), .T_GREEN(9), .T_YELLOW(3), .T_ALLRED(1), .T_WALK(6)
  ) dut (
    .clk(clk), .reset(reset), .tick(tick), .ped_req(ped_req),
    .flash_mode(flash_mode), .ns_light(ns_light), .ew_light(ew_light),
    .walk(walk), .ped_pending(ped_pending), .remaining(remaining),
    .phase(phase)
  );

  always #5 clk = ~clk;

  // Expected {ns_light, ew_light} for a non-FLASH phase code.
  function automatic logic [5:0] exp_lights(input int p);
    case (p)
      1: return {3'b100, 3'b001};
      2: return {3'b010, 3'b001};
      3: return {3'b001, 3'b100};
      4: return {3'b001, 3'b010};
      default: return {3'b001, 3'b001};
    endcase
  endfunction

  // One tick pulse, then idle so ticks arrive every 4 clk; ends on a negedge.
  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk) tick = 1'b1;
      @(negedge clk) tick = 1'b0;
      @(negedge clk);
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (phase !== 3'd0) begin errors++; $display("FAIL reset_phase got=%0d exp=0", phase); end
    checks++; if (remaining !== 4'd0) begin errors++; $display("FAIL reset_remaining got=%0d exp=0", remaining); end
    checks++; if ({ns_light, ew_light} !== 6'b001001) begin errors++; $display("FAIL reset_lights got=%b exp=001001", {ns_light, ew_light}); end
    checks++; if (walk !== 1'b0 || ped_pending !== 1'b0) begin errors++; $display("FAIL reset_walk_ped got=%b%b exp=00", walk, ped_pending); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  // Full 26-tick cycle with no requests.
  task automatic test_cycle;
    int ph [6] = '{1, 2, 0, 3, 4, 0};
    int du [6] = '{9, 3, 1, 9, 3, 1};
    for (int k = 0; k < 6; k++) begin
      for (int j = 0; j < du[k]; j++) begin
        tick_n(1);
        checks++; if (phase !== 3'(ph[k])) begin errors++; $display("FAIL cycle_phase k=%0d j=%0d got=%0d exp=%0d", k, j, phase, ph[k]); end
        checks++; if (remaining !== 4'(du[k] - 1 - j)) begin errors++; $display("FAIL cycle_remaining k=%0d j=%0d got=%0d exp=%0d", k, j, remaining, du[k] - 1 - j); end
        checks++; if ({ns_light, ew_light} !== exp_lights(ph[k]) || walk !== 1'b0) begin errors++; $display("FAIL cycle_lights k=%0d got=%b walk=%b exp=%b", k, {ns_light, ew_light}, walk, exp_lights(ph[k])); end
      end
    end
  endtask

  // Starts in ALLRED (remaining 0, next road NS); ends in NS_YELLOW with a pending request.
  task automatic test_countdown;
    tick_n(1);
    checks++; if (phase !== 3'd1 || remaining !== 4'd8) begin errors++; $display("FAIL cd_enter got=%0d/%0d exp=1/8", phase, remaining); end
    repeat (5) @(negedge clk);
    checks++; if (remaining !== 4'd8) begin errors++; $display("FAIL cd_hold got=%0d exp=8", remaining); end
    tick_n(1);
    checks++; if (remaining !== 4'd7) begin errors++; $display("FAIL cd_dec got=%0d exp=7", remaining); end
    @(negedge clk) ped_req = 1'b1;
    @(negedge clk) ped_req = 1'b0;
    checks++; if (ped_pending !== 1'b1) begin errors++; $display("FAIL cd_ped_latch got=%b exp=1", ped_pending); end
    tick_n(7);
    checks++; if (phase !== 3'd1 || remaining !== 4'd0) begin errors++; $display("FAIL cd_last got=%0d/%0d exp=1/0", phase, remaining); end
    tick_n(1);
    checks++; if (phase !== 3'd2 || remaining !== 4'd2) begin errors++; $display("FAIL cd_yellow got=%0d/%0d exp=2/2", phase, remaining); end
  endtask

  task automatic test_ped;
    checks++; if (ped_pending !== 1'b1) begin errors++; $display("FAIL ped_kept got=%b exp=1", ped_pending); end
    tick_n(3);
    checks++; if (phase !== 3'd0 || ped_pending !== 1'b1) begin errors++; $display("FAIL ped_allred got=%0d/%b exp=0/1", phase, ped_pending); end
    tick_n(1);
    checks++; if (phase !== 3'd5 || remaining !== 4'd5) begin errors++; $display("FAIL ped_walk got=%0d/%0d exp=5/5", phase, remaining); end
    checks++; if (walk !== 1'b1 || {ns_light, ew_light} !== 6'b001001 || ped_pending !== 1'b0) begin errors++; $display("FAIL ped_walk_out got=%b %b %b exp=1 001001 0", walk, {ns_light, ew_light}, ped_pending); end
    tick_n(5);
    checks++; if (phase !== 3'd5 || remaining !== 4'd0 || walk !== 1'b1) begin errors++; $display("FAIL ped_walk_end got=%0d/%0d/%b exp=5/0/1", phase, remaining, walk); end
    tick_n(1);
    checks++; if (phase !== 3'd3 || remaining !== 4'd8 || walk !== 1'b0) begin errors++; $display("FAIL ped_to_ew got=%0d/%0d/%b exp=3/8/0", phase, remaining, walk); end
  endtask

  // Button held from EW_GREEN through WALK: clear beats the press, no repeat WALK.
  task automatic test_ped_held;
    @(negedge clk) ped_req = 1'b1;
    @(negedge clk);
    checks++; if (ped_pending !== 1'b1) begin errors++; $display("FAIL held_latch got=%b exp=1", ped_pending); end
    tick_n(13);
    checks++; if (phase !== 3'd5 || ped_pending !== 1'b0) begin errors++; $display("FAIL held_walk got=%0d/%b exp=5/0", phase, ped_pending); end
    tick_n(5);
    checks++; if (phase !== 3'd5 || ped_pending !== 1'b0) begin errors++; $display("FAIL held_in_walk got=%0d/%b exp=5/0", phase, ped_pending); end
    @(negedge clk) tick = 1'b1;
    @(negedge clk) begin tick = 1'b0; ped_req = 1'b0; end
    checks++; if (phase !== 3'd1 || remaining !== 4'd8 || ped_pending !== 1'b0) begin errors++; $display("FAIL held_exit got=%0d/%0d/%b exp=1/8/0", phase, remaining, ped_pending); end
    tick_n(13);
    checks++; if (phase !== 3'd3 || walk !== 1'b0) begin errors++; $display("FAIL held_no_rewalk got=%0d/%b exp=3/0", phase, walk); end
  endtask

  task automatic test_flash;
    tick_n(3);
    checks++; if (phase !== 3'd3 || remaining !== 4'd5) begin errors++; $display("FAIL fl_pre got=%0d/%0d exp=3/5", phase, remaining); end
    @(negedge clk) flash_mode = 1'b1;
    tick_n(1);
    checks++; if (phase !== 3'd6 || remaining !== 4'd0 || walk !== 1'b0) begin errors++; $display("FAIL fl_enter got=%0d/%0d/%b exp=6/0/0", phase, remaining, walk); end
    checks++; if ({ns_light, ew_light} !== 6'b010010) begin errors++; $display("FAIL fl_on1 got=%b exp=010010", {ns_light, ew_light}); end
    @(negedge clk) ped_req = 1'b1;
    @(negedge clk) ped_req = 1'b0;
    checks++; if (ped_pending !== 1'b1) begin errors++; $display("FAIL fl_ped got=%b exp=1", ped_pending); end
    tick_n(1);
    checks++; if ({ns_light, ew_light} !== 6'b000000 || phase !== 3'd6) begin errors++; $display("FAIL fl_off got=%b exp=000000", {ns_light, ew_light}); end
    tick_n(1);
    checks++; if ({ns_light, ew_light} !== 6'b010010) begin errors++; $display("FAIL fl_on2 got=%b exp=010010", {ns_light, ew_light}); end
    @(negedge clk) flash_mode = 1'b0;
    tick_n(1);
    checks++; if (phase !== 3'd0 || remaining !== 4'd0 || {ns_light, ew_light} !== 6'b001001) begin errors++; $display("FAIL fl_exit got=%0d/%0d/%b exp=0/0/001001", phase, remaining, {ns_light, ew_light}); end
    checks++; if (ped_pending !== 1'b1) begin errors++; $display("FAIL fl_ped_kept got=%b exp=1", ped_pending); end
    tick_n(1);
    checks++; if (phase !== 3'd5) begin errors++; $display("FAIL fl_walk got=%0d exp=5", phase); end
    tick_n(6);
    checks++; if (phase !== 3'd1 || remaining !== 4'd8) begin errors++; $display("FAIL fl_ns got=%0d/%0d exp=1/8", phase, remaining); end
  endtask

  task automatic test_async_reset;
    tick_n(23);
    checks++; if (phase !== 3'd4 || remaining !== 4'd1) begin errors++; $display("FAIL ar_pre got=%0d/%0d exp=4/1", phase, remaining); end
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    checks++; if (phase !== 3'd0 || remaining !== 4'd0) begin errors++; $display("FAIL ar_state got=%0d/%0d exp=0/0", phase, remaining); end
    checks++; if ({ns_light, ew_light} !== 6'b001001 || walk !== 1'b0) begin errors++; $display("FAIL ar_lights got=%b/%b exp=001001/0", {ns_light, ew_light}, walk); end
    @(negedge clk) reset = 1'b0;
    tick_n(1);
    checks++; if (phase !== 3'd1 || remaining !== 4'd8) begin errors++; $display("FAIL ar_after got=%0d/%0d exp=1/8", phase, remaining); end
  endtask

  initial begin
    test_reset();
    test_cycle();
    test_countdown();
    test_ped();
    test_ped_held();
    test_flash();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
